// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// ex_mem_pipe : EX->MEM pipeline register, valid/ready with 2-entry skid buffer
// Optional: STALL_COUNT_EN adds stall_cycles_out.      Rev 1.0 - initial
// ============================================================================

package ex_mem_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       alu_src;
  } riscv_control_t;
endpackage

module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_INDEX = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 zero_in,
  input  riscv_control_t       ctrl_vector_in,
  input  logic [WIDTH-1:0]     alu_result_in,
  input  logic [WIDTH-1:0]     store_data_in,
  input  logic [REG_INDEX-1:0] rd_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 zero_out,
  output riscv_control_t       ctrl_vector_out,
  output logic [WIDTH-1:0]     alu_result_out,
  output logic [WIDTH-1:0]     store_data_out,
  output logic [REG_INDEX-1:0] rd_out
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]          stall_cycles_out
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 zero;
    riscv_control_t       ctrl;
    logic [WIDTH-1:0]     alu;
    logic [WIDTH-1:0]     store;
    logic [REG_INDEX-1:0] rd;
  } entry_t;

  state_t state_q;
  entry_t m_q;
  entry_t s_q;
  logic   ready_q;
  entry_t in_entry;
  logic   m_valid;
  logic   accept;
  logic   drain;

  assign in_entry = {zero_in, ctrl_vector_in, alu_result_in, store_data_in, rd_in};
  assign m_valid  = (state_q != ST_EMPTY);
  assign accept   = valid_in & ready_q;
  assign drain    = m_valid & ready_in;

  // Flush wins over everything; a same-cycle drain is already consumed by MEM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b1;
    end else if (flush_in) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_q     <= in_entry;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            m_q <= in_entry;
          end else if (drain) begin
            state_q <= ST_EMPTY;
          end else if (accept) begin
            s_q     <= in_entry;
            state_q <= ST_SKID;
            ready_q <= 1'b0;
          end
        end
        ST_SKID: begin
          if (drain) begin
            m_q     <= s_q;
            state_q <= ST_FULL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Bubbles must not leak control bits into MEM.
  assign valid_out       = m_valid;
  assign ready_out       = ready_q;
  assign zero_out        = m_valid & m_q.zero;
  assign ctrl_vector_out = m_valid ? m_q.ctrl : '0;
  assign rd_out          = m_valid ? m_q.rd : '0;
  assign alu_result_out  = m_q.alu;
  assign store_data_out  = m_q.store;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q <= 32'd0;
    end else if (m_valid && !ready_in) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_out = stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Pipeline register between the execute stage and the MEM stage. Carries the ALU result (memory address), store data, zero flag, destination register and control vector. Uses a valid/ready handshake backed by a two-entry skid buffer, so MEM backpressure never creates a combinational ready path into EX. Supports a flush when a taken branch resolves in MEM.

Parameters:
WIDTH, 32, datapath width of address and store data
REG_INDEX, 5, width of destination register index

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  asynchronous reset, active-high
flush_in  input  1  kill all held entries (taken branch, pc_src from MEM)
valid_in  input  1  EX presents a valid instruction
ready_out  output  1  this block can accept from EX; registered
zero_in  input  1  ALU zero flag
ctrl_vector_in  input  riscv_control_t  control vector from EX
alu_result_in  input  WIDTH  ALU result / memory address
store_data_in  input  WIDTH  rs2 data for stores
rd_in  input  REG_INDEX  destination register index
valid_out  output  1  entry presented to MEM is valid
ready_in  input  1  MEM accepts the presented entry
zero_out  output  1  held zero flag
ctrl_vector_out  output  riscv_control_t  held control vector; all zeros when valid_out=0
alu_result_out  output  WIDTH  held address
store_data_out  output  WIDTH  held store data
rd_out  output  REG_INDEX  held destination index

Behaviour:
- Storage: main entry M drives the outputs; skid entry S holds an overflow entry. Each has a valid bit.
- States: EMPTY (M and S invalid), FULL (M valid), SKID (M and S valid).
- ready_out = !S.valid, registered.
- accept = valid_in & ready_out. drain = valid_out & ready_in.
- EMPTY: accept -> M <= inputs, go to FULL; otherwise stay.
- FULL:
  - accept & drain -> M <= inputs, stay FULL.
  - drain only -> EMPTY.
  - accept only -> S <= inputs, go to SKID, ready_out falls next cycle.
  - neither -> hold.
- SKID: drain -> M <= S, go to FULL, ready_out rises next cycle. Otherwise hold. No accept is possible in SKID.
- Latency: an accepted entry reaches the outputs one cycle later. Order is strictly FIFO (M before S).
- Bubble: when valid_out=0, ctrl_vector_out, zero_out and rd_out are forced to 0. MEM's we/re and branch bits are therefore deasserted. alu_result_out and store_data_out hold their previous values (don't-care).
- flush_in: the next state is EMPTY, both valid bits clear, and ready_out is 1 next cycle.
  - flush_in overrides accept and drain in the same cycle. A simultaneous valid_in is discarded, not stored.
  - An entry draining in the same cycle as flush counts as consumed by MEM; flush only removes younger entries.
- Reset (async, rst_in=1):
  - State EMPTY, valid_out=0, ready_out=1.
  - All payload registers and outputs are 0.
  - Reset asserted mid-operation drops M and S immediately, with no clock edge needed.
- Payload registers need no reset for function but are reset for X-free simulation.

Optional Feature:
Macro STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles_out [31:0].
  - Increments by 1 every cycle with valid_out=1 and ready_in=0. Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst_in. Not affected by flush_in.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Pass-through: reset, then valid_in=1 with alu_result_in=0x100, rd_in=3 for one cycle, ready_in=1 -> next cycle valid_out=1, alu_result_out=0x100, rd_out=3; following cycle valid_out=0, ctrl_vector_out=0.
- Backpressure/skid: ready_in=0, send A=0x10 then B=0x20 on consecutive cycles -> outputs hold A, ready_out=0 after B. Raise ready_in -> A, then B on consecutive cycles; ready_out=1 one cycle after A drains.
- Back-to-back streaming: valid_in=1 and ready_in=1 for 8 cycles with results 0..7 -> outputs 0..7 in order, ready_out constantly 1.
- Flush in SKID: M=A, S=B held, assert flush_in with valid_in=1 (C) -> next cycle valid_out=0, ready_out=1, ctrl_vector_out=0; C never appears.
- Async reset mid-operation: in SKID state pulse rst_in between clock edges -> valid_out=0 and ready_out=1 immediately; no entry emerges afterwards.
- STALL_COUNT_EN: hold a valid entry with ready_in=0 for 5 cycles -> stall_cycles_out=5; after release it stays at 5.
